// File: rtl/axis_wfrm_gain_fifo_if.sv
// AXI-Stream waveform bus: tdata/tlast with valid/ready handshake.
// master drives payload and valid, slave drives ready.
interface axis_wfrm_gain_fifo_if #(
  parameter int W = 16
) ();
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tlast;
  logic         tready;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/axis_wfrm_gain_fifo.sv
// Waveform output stage: signed gain/offset with saturation into a
// primed FIFO feeding the DAC stream, with frame and underrun counters.
module axis_wfrm_gain_fifo #(
  parameter int AXIS_TDATA_WIDTH = 16,
  parameter int GAIN_WIDTH       = 16,
  parameter int FIFO_ADDR_WIDTH  = 4
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic [GAIN_WIDTH+AXIS_TDATA_WIDTH-1:0] cfg_data,
  output logic        underrun,
  output logic [31:0] sts_data,
  axis_wfrm_gain_fifo_if.slave  s_axis,
  axis_wfrm_gain_fifo_if.master m_axis
);

  localparam int W     = AXIS_TDATA_WIDTH;
  localparam int G     = GAIN_WIDTH;
  localparam int P     = W + G;
  localparam int A     = FIFO_ADDR_WIDTH;
  localparam int DEPTH = 1 << A;

  localparam logic [A+1:0] DEPTH_V = (A+2)'(DEPTH);
  localparam logic [A:0]   HALF_V  = (A+1)'(DEPTH / 2);

  typedef enum logic {
    PRIME,
    RUN
  } state_t;

  state_t state, state_n;

  logic signed [G-1:0] gain;
  logic signed [W-1:0] offset;
  logic                in_fire;

  logic                v1;
  logic                l1;
  logic signed [P-1:0] prod1;
  logic signed [W-1:0] off1;

  logic signed [P-1:0] shifted;
  logic        [P:0]   sum;
  logic        [W-1:0] sat;

  logic                v2;
  logic                l2;
  logic        [W-1:0] d2;

  logic [W:0]   mem [DEPTH];
  logic [A-1:0] wr_ptr;
  logic [A-1:0] rd_ptr;
  logic [A:0]   count;
  logic [A+1:0] occ;
  logic [W:0]   head;
  logic         empty;
  logic         wr;
  logic         rd;

  logic         last_seen;
  logic         last_out;
  logic         leave_prime;
  logic         und_n;
  logic [15:0]  frame_cnt;
  logic [15:0]  underrun_cnt;

  assign gain    = cfg_data[G-1:0];
  assign offset  = cfg_data[P-1:G];
  assign in_fire = s_axis.tvalid & s_axis.tready;

  assign occ = (A+2)'(count) + (A+2)'(v1) + (A+2)'(v2);
  assign s_axis.tready = aresetn & (occ < DEPTH_V);

  // S1: full-precision product, cfg captured with the beat
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      v1    <= 1'b0;
      l1    <= 1'b0;
      prod1 <= '0;
      off1  <= '0;
    end else begin
      v1 <= in_fire;
      if (in_fire) begin
        l1    <= s_axis.tlast;
        prod1 <= $signed(s_axis.tdata) * gain;
        off1  <= offset;
      end
    end
  end

  assign shifted = prod1 >>> (G - 2);
  assign sum = {shifted[P-1], shifted}
             + {{(P+1-W){off1[W-1]}}, off1};

  // Fits only when every bit above the output sign matches it
  always_comb begin
    sat = sum[W-1:0];
    if (!(&sum[P:W-1]) && (|sum[P:W-1])) begin
      if (sum[P]) sat = {1'b1, {(W-1){1'b0}}};
      else        sat = {1'b0, {(W-1){1'b1}}};
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      v2 <= 1'b0;
      l2 <= 1'b0;
      d2 <= '0;
    end else begin
      v2 <= v1;
      if (v1) begin
        l2 <= l1;
        d2 <= sat;
      end
    end
  end

  assign wr    = v2;
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];
  assign rd    = m_axis.tvalid & m_axis.tready;

  always_ff @(posedge aclk) begin
    if (wr) mem[wr_ptr] <= {l2, d2};
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr, rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign m_axis.tvalid = (state == RUN) & ~empty;
  assign m_axis.tdata  = empty ? '0 : head[W-1:0];
  assign m_axis.tlast  = empty ? 1'b0 : head[W];

  always_ff @(posedge aclk) begin
    if (!aresetn) state <= PRIME;
    else          state <= state_n;
  end

  always_comb begin
    state_n     = state;
    leave_prime = 1'b0;
    und_n       = 1'b0;
    unique case (state)
      PRIME: begin
        if (count >= HALF_V || last_seen) begin
          state_n     = RUN;
          leave_prime = 1'b1;
        end
      end
      RUN: begin
        if (empty) begin
          if (last_out) begin
            state_n = PRIME;
          end else if (m_axis.tready) begin
            state_n = PRIME;
            und_n   = 1'b1;
          end
        end
      end
      default: state_n = PRIME;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      last_seen <= 1'b0;
      last_out  <= 1'b0;
    end else begin
      if (leave_prime)   last_seen <= 1'b0;
      else if (wr && l2) last_seen <= 1'b1;
      if (rd) last_out <= head[W];
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      underrun     <= 1'b0;
      underrun_cnt <= '0;
      frame_cnt    <= '0;
    end else begin
      underrun <= und_n;
      if (und_n && underrun_cnt != 16'hFFFF)
        underrun_cnt <= underrun_cnt + 1'b1;
      if (rd && head[W] && frame_cnt != 16'hFFFF)
        frame_cnt <= frame_cnt + 1'b1;
    end
  end

  assign sts_data = {frame_cnt, underrun_cnt};

endmodule

// File: tb/tb_axis_wfrm_gain_fifo.sv
// Bench for axis_wfrm_gain_fifo: directed beats, expected outputs
// queued at issue and checked by an independent output monitor.
module tb_axis_wfrm_gain_fifo;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [31:0] cfg_data;
  logic        underrun;
  logic [31:0] sts_data;

  axis_wfrm_gain_fifo_if #(.W(16)) s_if ();
  axis_wfrm_gain_fifo_if #(.W(16)) m_if ();

  axis_wfrm_gain_fifo #(
    .AXIS_TDATA_WIDTH(16),
    .GAIN_WIDTH(16),
    .FIFO_ADDR_WIDTH(4)
  ) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .cfg_data(cfg_data),
    .underrun(underrun),
    .sts_data(sts_data),
    .s_axis(s_if.slave),
    .m_axis(m_if.master)
  );

  always #5 aclk = ~aclk;

  int vectors = 0;
  int misc = 0;
  int und_seen = 0;
  logic und_prev = 1'b0;
  logic [16:0] exp_q[$];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      misc++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Output monitor: pops on every DAC-side handshake
  always @(negedge aclk) begin
    if (aresetn) begin
      if (underrun) begin
        und_seen++;
        if (und_prev) check("underrun_width", 32'(und_prev), 32'd0);
      end
      und_prev <= underrun;
      if (m_if.tvalid && m_if.tready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          misc++;
          $display("FAIL spurious_beat: got %h expected none",
                   {m_if.tlast, m_if.tdata});
        end else begin
          check("beat", {15'b0, m_if.tlast, m_if.tdata},
                {15'b0, exp_q.pop_front()});
        end
      end
    end else begin
      und_prev <= 1'b0;
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic set_cfg(input logic [15:0] g, input logic [15:0] o);
    cfg_data = {o, g};
  endtask

  task automatic push(input logic [15:0] d, input logic l, output bit ok);
    s_if.tdata  = d;
    s_if.tlast  = l;
    s_if.tvalid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge aclk);
      if (s_if.tready) ok = 1'b1;
      tick();
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic push_exp(input logic [15:0] d, input logic l,
                          input logic [15:0] e);
    bit ok;
    exp_q.push_back({l, e});
    push(d, l, ok);
    check("accept", 32'(ok), 32'd1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++)
      @(negedge aclk);
    check("drain", exp_q.size(), 32'd0);
    repeat (4) @(negedge aclk);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int hi;
    int und0;
    bit ok;
    aresetn     = 1'b0;
    cfg_data    = '0;
    s_if.tdata  = '0;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b0;
    repeat (3) tick();
    @(negedge aclk);
    check("rst_s_tready", 32'(s_if.tready), 32'd0);
    check("rst_m_tvalid", 32'(m_if.tvalid), 32'd0);
    check("rst_m_tlast", 32'(m_if.tlast), 32'd0);
    check("rst_m_tdata", 32'(m_if.tdata), 32'd0);
    check("rst_sts", sts_data, 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    tick();
    aresetn = 1'b1;
    tick();

    // Unity gain frame
    set_cfg(16'd16384, 16'd0);
    m_if.tready = 1'b1;
    for (int i = 0; i < 8; i++)
      push_exp(16'(i), i == 7, 16'(i));
    wait_drain();
    check("t1_sts", sts_data, 32'h0001_0000);
    check("t1_no_underrun", 32'(und_seen), 32'd0);

    // Saturation and scaling
    set_cfg(16'd32767, 16'd0);
    push_exp(16'h7000, 1'b1, 16'h7FFF);
    push_exp(16'h9000, 1'b1, 16'h8000);
    set_cfg(16'd16384, 16'd100);
    push_exp(16'h7FF0, 1'b1, 16'h7FFF);
    set_cfg(16'd8192, 16'd0);
    push_exp(16'h0100, 1'b1, 16'h0080);
    wait_drain();
    check("t2_sts", sts_data, 32'h0005_0000);

    // Backpressure: 16 fit, the 17th waits
    set_cfg(16'd16384, 16'd0);
    m_if.tready = 1'b0;
    for (int i = 0; i < 16; i++)
      push_exp(16'(100 + i), 1'b0, 16'(100 + i));
    s_if.tdata  = 16'd116;
    s_if.tvalid = 1'b1;
    hi = 0;
    repeat (8) begin
      @(negedge aclk);
      if (s_if.tready) hi++;
    end
    check("t3_tready_low", 32'(hi), 32'd0);
    check("t3_full_valid", 32'(m_if.tvalid), 32'd1);
    check("t3_full_head", 32'(m_if.tdata), 32'd100);
    tick();
    m_if.tready = 1'b1;
    for (int i = 16; i < 20; i++)
      push_exp(16'(100 + i), i == 19, 16'(100 + i));
    wait_drain();
    check("t3_sts", sts_data, 32'h0006_0000);

    // Underrun after an unterminated burst
    for (int i = 0; i < 8; i++)
      push_exp(16'(200 + i), 1'b0, 16'(200 + i));
    for (int i = 0; i < 300 && exp_q.size() != 0; i++)
      @(negedge aclk);
    check("t4_drain", exp_q.size(), 32'd0);
    for (int i = 0; i < 30 && und_seen == 0; i++)
      @(negedge aclk);
    check("t4_underrun_pulse", 32'(und_seen), 32'd1);
    repeat (3) @(negedge aclk);
    check("t4_sts", sts_data, 32'h0006_0001);
    check("t4_underrun_clr", 32'(underrun), 32'd0);
    tick();
    for (int i = 0; i < 7; i++)
      push_exp(16'(300 + i), 1'b0, 16'(300 + i));
    repeat (10) @(negedge aclk);
    check("t4_prime_hold", 32'(m_if.tvalid), 32'd0);
    tick();
    push_exp(16'd307, 1'b1, 16'd307);
    wait_drain();
    check("t4_sts2", sts_data, 32'h0007_0001);

    // Short frame released by tlast
    push_exp(16'hFFFB, 1'b0, 16'hFFFB);
    push_exp(16'h1234, 1'b0, 16'h1234);
    push_exp(16'h0007, 1'b1, 16'h0007);
    wait_drain();
    repeat (5) @(negedge aclk);
    check("t5_sts", sts_data, 32'h0008_0001);
    check("t5_idle", 32'(m_if.tvalid), 32'd0);
    check("t5_und_total", 32'(und_seen), 32'd1);
    tick();

    // Reset mid-frame discards buffered beats
    und0 = und_seen;
    m_if.tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push(16'(500 + i), 1'b0, ok);
      check("t6_pre_accept", 32'(ok), 32'd1);
    end
    repeat (3) tick();
    aresetn = 1'b0;
    tick();
    @(negedge aclk);
    check("t6_s_tready", 32'(s_if.tready), 32'd0);
    check("t6_m_tvalid", 32'(m_if.tvalid), 32'd0);
    check("t6_m_tlast", 32'(m_if.tlast), 32'd0);
    check("t6_m_tdata", 32'(m_if.tdata), 32'd0);
    check("t6_sts", sts_data, 32'd0);
    check("t6_underrun", 32'(underrun), 32'd0);
    exp_q.delete();
    tick();
    aresetn = 1'b1;
    m_if.tready = 1'b1;
    tick();
    for (int i = 5; i < 10; i++)
      push_exp(16'(500 + i), i == 9, 16'(500 + i));
    wait_drain();
    check("t6_sts_after", sts_data, 32'h0001_0000);
    check("t6_no_underrun", 32'(und_seen - und0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
    $finish;
  end

endmodule
